// File: rtl/wire_edge_counter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : wire_edge_counter
// Purpose  : Synchronizes an asynchronous wire level and debounces it with a
//            four-state filter. Emits rise/fall pulses on accepted edges and
//            counts accepted rises, accepted falls and aborted transitions.
//            Build macro WIRE_EDGE_SAT_EN: when defined, the counters saturate
//            at all-ones. When undefined, they wrap to zero.
// Revision : 1.0 - initial release
// ============================================================================
module wire_edge_counter #(
    parameter int STABLE_CYC = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             en,
    input  logic             clr,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic [CNT_W-1:0] glitch_cnt
);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_PEND = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_PEND = 2'd3
    } state_t;

    // Value of the stability counter on the cycle that accepts a new level.
    localparam logic [7:0] c_STAB_LAST = 8'(STABLE_CYC - 1);

    logic             r_s1;
    logic             r_s2;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_stab;
    logic [7:0]       w_stab_nxt;
    logic             w_rise;
    logic             w_fall;
    logic             w_glitch;
    logic [CNT_W-1:0] r_rise_cnt;
    logic [CNT_W-1:0] r_fall_cnt;
    logic [CNT_W-1:0] r_glitch_cnt;

    // Counter increment: saturating or wrapping depending on the build.
    function automatic logic [CNT_W-1:0] f_bump(input logic [CNT_W-1:0] v);
`ifdef WIRE_EDGE_SAT_EN
        f_bump = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
`else
        f_bump = v + CNT_W'(1);
`endif
    endfunction

    // Two-flop synchronizer; keeps running regardless of en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= din;
            r_s2 <= r_s1;
        end
    end

    // State and stability-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOW;
            r_stab  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_stab  <= w_stab_nxt;
        end
    end

    // Next-state logic. The accepting cycle is decoded combinationally so
    // that level and the edge pulse appear right after the edge on which the
    // last required stable sample is seen. en low holds everything.
    always_comb begin
        w_state_nxt = r_state;
        w_stab_nxt  = r_stab;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_glitch    = 1'b0;
        if (en) begin
            case (r_state)
                ST_LOW: begin
                    if (r_s2) begin
                        w_state_nxt = ST_RISE_PEND;
                        w_stab_nxt  = 8'd0;
                    end
                end
                ST_RISE_PEND: begin
                    if (!r_s2) begin
                        w_state_nxt = ST_LOW;
                        w_glitch    = 1'b1;
                    end else if (r_stab == c_STAB_LAST) begin
                        w_state_nxt = ST_HIGH;
                        w_rise      = 1'b1;
                    end else begin
                        w_stab_nxt  = r_stab + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (!r_s2) begin
                        w_state_nxt = ST_FALL_PEND;
                        w_stab_nxt  = 8'd0;
                    end
                end
                ST_FALL_PEND: begin
                    if (r_s2) begin
                        w_state_nxt = ST_HIGH;
                        w_glitch    = 1'b1;
                    end else if (r_stab == c_STAB_LAST) begin
                        w_state_nxt = ST_LOW;
                        w_fall      = 1'b1;
                    end else begin
                        w_stab_nxt  = r_stab + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_LOW;
                    w_stab_nxt  = 8'd0;
                end
            endcase
        end
    end

    // Event counters; clr wins over any increment, even with en low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rise_cnt   <= '0;
            r_fall_cnt   <= '0;
            r_glitch_cnt <= '0;
        end else if (clr) begin
            r_rise_cnt   <= '0;
            r_fall_cnt   <= '0;
            r_glitch_cnt <= '0;
        end else begin
            if (w_rise)   r_rise_cnt   <= f_bump(r_rise_cnt);
            if (w_fall)   r_fall_cnt   <= f_bump(r_fall_cnt);
            if (w_glitch) r_glitch_cnt <= f_bump(r_glitch_cnt);
        end
    end

    // Filtered level: the held level, flipped during the accepting cycle.
    assign level      = ((r_state == ST_HIGH) || (r_state == ST_FALL_PEND)) ^ (w_rise | w_fall);
    assign rise       = w_rise;
    assign fall       = w_fall;
    assign rise_cnt   = r_rise_cnt;
    assign fall_cnt   = r_fall_cnt;
    assign glitch_cnt = r_glitch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wire_edge_counter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_wire_edge_counter
// Purpose  : Scoreboard bench for wire_edge_counter. Two instances are used:
//            one with STABLE_CYC=4 and one with STABLE_CYC=1. Both use
//            CNT_W=2. The bench applies directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wire_edge_counter;

    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [1:0]         level;
        logic [1:0]         rise;
        logic [1:0]         fall;
        logic [1:0][CW-1:0] rc;
        logic [1:0][CW-1:0] fc;
        logic [1:0][CW-1:0] gc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din = 1'b0;
    logic          en  = 1'b1;
    logic          clr = 1'b0;
    logic [1:0]    level;
    logic [1:0]    rise;
    logic [1:0]    fall;
    logic [CW-1:0] rcnt [2];
    logic [CW-1:0] fcnt [2];
    logic [CW-1:0] gcnt [2];

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    // Reference model: synchronizer delay line plus, per instance, the
    // accepted level, the current run length of samples that disagree with
    // that level, and the three event totals.
    bit m_s1, m_s2;
    bit m_L  [2];
    int m_r  [2];
    int m_rc [2];
    int m_fc [2];
    int m_gc [2];

    always #5 clk = ~clk;

    wire_edge_counter #(.STABLE_CYC(4), .CNT_W(CW)) u_dut0 (
        .clk(clk), .rst(rst), .din(din), .en(en), .clr(clr),
        .level(level[0]), .rise(rise[0]), .fall(fall[0]),
        .rise_cnt(rcnt[0]), .fall_cnt(fcnt[0]), .glitch_cnt(gcnt[0])
    );

    wire_edge_counter #(.STABLE_CYC(1), .CNT_W(CW)) u_dut1 (
        .clk(clk), .rst(rst), .din(din), .en(en), .clr(clr),
        .level(level[1]), .rise(rise[1]), .fall(fall[1]),
        .rise_cnt(rcnt[1]), .fall_cnt(fcnt[1]), .glitch_cnt(gcnt[1])
    );

    function automatic int stab(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int bump(input int c);
`ifdef WIRE_EDGE_SAT_EN
        return (c == CMAX) ? c : c + 1;
`else
        return (c + 1) % (CMAX + 1);
`endif
    endfunction

    task automatic model_reset();
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_L[i]  = 1'b0;
            m_r[i]  = 0;
            m_rc[i] = 0;
            m_fc[i] = 0;
            m_gc[i] = 0;
        end
    endtask

    // A new level is taken once the disagreeing sample run reaches
    // STABLE_CYC+1 samples. A run that ends early counts as a glitch.
    task automatic model_update(input bit d, input bit e, input bit c);
        for (int i = 0; i < 2; i++) begin
            bit ri, fi, gi;
            ri = 1'b0;
            fi = 1'b0;
            gi = 1'b0;
            if (e) begin
                if (m_s2 != m_L[i]) begin
                    m_r[i] = m_r[i] + 1;
                    if (m_r[i] > stab(i)) begin
                        if (m_L[i]) fi = 1'b1;
                        else        ri = 1'b1;
                        m_L[i] = !m_L[i];
                        m_r[i] = 0;
                    end
                end else begin
                    if (m_r[i] > 0) gi = 1'b1;
                    m_r[i] = 0;
                end
            end
            if (c) begin
                m_rc[i] = 0;
                m_fc[i] = 0;
                m_gc[i] = 0;
            end else begin
                if (ri) m_rc[i] = bump(m_rc[i]);
                if (fi) m_fc[i] = bump(m_fc[i]);
                if (gi) m_gc[i] = bump(m_gc[i]);
            end
        end
        m_s2 = m_s1;
        m_s1 = d;
    endtask

    // One clock cycle. Inputs are applied at the falling edge. The expected
    // outputs for that cycle are pushed. The model then advances at the
    // rising edge.
    task automatic step(input bit d, input bit e, input bit c, input bit r);
        exp_t x;
        @(negedge clk);
        din = d;
        en  = e;
        clr = c;
        rst = r;
        if (r) model_reset();
        for (int i = 0; i < 2; i++) begin
            bit acc;
            acc = e && !r && (m_s2 != m_L[i]) && (m_r[i] == stab(i));
            x.level[i] = m_L[i] ^ acc;
            x.rise[i]  = acc && !m_L[i];
            x.fall[i]  = acc && m_L[i];
            x.rc[i]    = CW'(m_rc[i]);
            x.fc[i]    = CW'(m_fc[i]);
            x.gc[i]    = CW'(m_gc[i]);
        end
        sb.push_back(x);
        @(posedge clk);
        if (!r) model_update(d, e, c);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor samples the outputs mid-cycle and compares them with the
    // oldest pending expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                for (int i = 0; i < 2; i++) begin
                    check($sformatf("level[%0d]", i),      int'(level[i]), int'(x.level[i]));
                    check($sformatf("rise[%0d]", i),       int'(rise[i]),  int'(x.rise[i]));
                    check($sformatf("fall[%0d]", i),       int'(fall[i]),  int'(x.fall[i]));
                    check($sformatf("rise_cnt[%0d]", i),   int'(rcnt[i]),  int'(x.rc[i]));
                    check($sformatf("fall_cnt[%0d]", i),   int'(fcnt[i]),  int'(x.fc[i]));
                    check($sformatf("glitch_cnt[%0d]", i), int'(gcnt[i]),  int'(x.gc[i]));
                end
            end
        end
    end

    initial begin
        model_reset();
        // Reset.
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0);
        // Clean rise, then a clean fall.
        repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0);
        // Short pulse: a glitch for the slow filter.
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0);
        // Clear held across an accepted fall.
        repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);
        // Reset while a rise is pending, then din stays high.
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (8) step(1'b1, 1'b1, 1'b0, 1'b0);
        // Enable low across a din toggle, including a clear.
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0);
        // Five or more rises, enough to exercise counter overflow.
        for (int k = 0; k < 6; k++) begin
            repeat (7) step(1'b1, 1'b1, 1'b0, 1'b0);
            repeat (7) step(1'b0, 1'b1, 1'b0, 1'b0);
        end
        // Random runs of din with occasional enable drops, clears and resets.
        for (int k = 0; k < 300; k++) begin
            int len;
            bit d;
            len = $urandom_range(1, 8);
            d   = 1'($urandom);
            for (int j = 0; j < len; j++) begin
                step(d,
                     $urandom_range(0, 9)   != 0,
                     $urandom_range(0, 29)  == 0,
                     $urandom_range(0, 199) == 0);
            end
        end
        repeat (2) @(negedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
